// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch stage with an internal PC, a synchronous-read instruction memory and
//   a small prefetch FIFO of {pc, instr} entries that ID drains with valid/ready.
//   Supports redirect (flush), stepped debug execution, HALT-word detection and
//   an advance-enabled cycle counter.
//
// Ports
//   i_clk, i_rst         clock (rising edge), async active-low reset
//   i_redirect(_pc)      taken branch/jump from EX; flushes queue, reloads PC
//   i_debug_mode, i_step stepped execution; one fetch per step pulse
//   i_ready              ID accepts the head entry
//   i_imem_wr_*          loader write port (byte address, word data)
//   o_valid/o_instr/o_pc head entry (instr/pc forced to 0 when empty)
//   o_fetch_pc           next PC to be issued
//   o_occupancy          entries currently queued
//   o_halted             HALT word enqueued, issuing stopped
//   o_cycle_count        cycles with advance=1 while not halted
module instruction_fetch_queue #(
  parameter int unsigned       NBITS      = 32,
  parameter int unsigned       MEM_DEPTH  = 256,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [NBITS-1:0]  RESET_PC   = '0,
  parameter logic [NBITS-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_redirect,
  input  logic [NBITS-1:0]                i_redirect_pc,
  input  logic                            i_debug_mode,
  input  logic                            i_step,
  input  logic                            i_ready,
  input  logic                            i_imem_wr_en,
  input  logic [NBITS-1:0]                i_imem_wr_addr,
  input  logic [NBITS-1:0]                i_imem_wr_data,
  output logic                            o_valid,
  output logic [NBITS-1:0]                o_instr,
  output logic [NBITS-1:0]                o_pc,
  output logic [NBITS-1:0]                o_fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]     o_occupancy,
  output logic                            o_halted,
  output logic [NBITS-1:0]                o_cycle_count
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam logic [FW+1:0] DEPTH_L = FIFO_DEPTH[FW+1:0];

  // Instruction memory and its registered read port
  logic [NBITS-1:0] mem [MEM_DEPTH];
  logic [NBITS-1:0] rd_data;

  // Fetch state
  logic [NBITS-1:0] fetch_pc;
  logic             inflight;
  logic [NBITS-1:0] inflight_pc;
  logic             halted;
  logic [NBITS-1:0] cycle_count;

  // Prefetch queue
  logic [NBITS-1:0] q_pc    [FIFO_DEPTH];
  logic [NBITS-1:0] q_instr [FIFO_DEPTH];
  logic [FW-1:0]    wr_ptr, rd_ptr;
  logic [FW:0]      count;

  logic advance, halt_ret, room, issue, enq, pop;

  // Only the word-index bits of the loader address select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_imem_wr_addr[NBITS-1:AW+2], i_imem_wr_addr[1:0]};

  assign advance  = ~i_debug_mode | i_step;

  // A HALT word returning this cycle also blocks the issue, so nothing
  // younger than the HALT is fetched and fetch_pc stays on the word after it.
  assign halt_ret = inflight & (rd_data == HALT_WORD);

  // Reserve a slot for the read in flight so the queue can never overflow.
  assign room  = ({1'b0, count} + {{(FW+1){1'b0}}, inflight}) < DEPTH_L;
  assign issue = advance & ~halted & ~i_redirect & ~halt_ret & room;

  // Redirect kills the returning read and discards any pop this cycle.
  assign enq   = inflight & ~i_redirect;
  assign pop   = o_valid & i_ready & ~i_redirect;

  // Memory: read-first on same-word read/write because both are NBA updates.
  // Contents survive reset so the loader can fill memory while held in reset.
  always_ff @(posedge i_clk) begin
    if (issue)
      rd_data <= mem[fetch_pc[AW+1:2]];
    if (i_imem_wr_en)
      mem[i_imem_wr_addr[AW+1:2]] <= i_imem_wr_data;
  end

  // Queue storage; valid-ness is tracked by count, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= rd_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      if (advance & ~halted)
        cycle_count <= cycle_count + 1'b1;

      if (i_redirect) begin
        fetch_pc <= i_redirect_pc;
        inflight <= 1'b0;
        halted   <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + NBITS'(4);
        end
        if (enq) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (halt_ret)
            halted <= 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        case ({enq, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_valid       = (count != '0);
  assign o_pc          = o_valid ? q_pc[rd_ptr]    : '0;
  assign o_instr       = o_valid ? q_instr[rd_ptr] : '0;
  assign o_fetch_pc    = fetch_pc;
  assign o_occupancy   = count;
  assign o_halted      = halted;
  assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;
  localparam int NBITS      = 32;
  localparam int MEM_DEPTH  = 256;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(MEM_DEPTH);
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_debug_mode = 1'b0;
  logic        i_step = 1'b0;
  logic        i_ready = 1'b0;
  logic        i_imem_wr_en = 1'b0;
  logic [31:0] i_imem_wr_addr = '0;
  logic [31:0] i_imem_wr_data = '0;
  logic        o_valid;
  logic [31:0] o_instr, o_pc, o_fetch_pc, o_cycle_count;
  logic [2:0]  o_occupancy;
  logic        o_halted;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .NBITS(NBITS), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
    .RESET_PC(RESET_PC), .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_debug_mode(i_debug_mode), .i_step(i_step), .i_ready(i_ready),
    .i_imem_wr_en(i_imem_wr_en), .i_imem_wr_addr(i_imem_wr_addr),
    .i_imem_wr_data(i_imem_wr_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_fetch_pc(o_fetch_pc),
    .o_occupancy(o_occupancy), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      mq[$];
  logic [31:0] mmem [MEM_DEPTH];
  logic [31:0] m_fpc, m_cnt, m_ipc, m_iinstr;
  bit          m_infl, m_halted;

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc = RESET_PC; m_cnt = 0; m_ipc = 0; m_iinstr = 0;
    m_infl = 0; m_halted = 0;
  endtask

  // One clock edge of the fetch stage, evaluated from the inputs present now.
  task automatic model_edge();
    bit adv, do_pop, halt_ret, do_issue;
    entry_t e;
    if (i_rst) begin
      adv      = !i_debug_mode || i_step;
      do_pop   = (mq.size() > 0) && i_ready && !i_redirect;
      halt_ret = m_infl && (m_iinstr == HALT);
      do_issue = adv && !m_halted && !i_redirect && !halt_ret &&
                 (mq.size() + int'(m_infl) < FIFO_DEPTH);
      if (adv && !m_halted) m_cnt = m_cnt + 1;
      if (i_redirect) begin
        mq.delete(); m_infl = 0; m_halted = 0; m_fpc = i_redirect_pc;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (m_infl) begin
          e.pc = m_ipc; e.instr = m_iinstr;
          mq.push_back(e);
          if (halt_ret) m_halted = 1;
        end
        m_infl = do_issue;
        if (do_issue) begin
          m_ipc = m_fpc; m_iinstr = mmem[widx(m_fpc)]; m_fpc = m_fpc + 4;
        end
      end
    end
    // write after read: same-word read returns old data
    if (i_imem_wr_en) mmem[widx(i_imem_wr_addr)] = i_imem_wr_data;
  endtask

  task automatic check_model();
    bit v;
    v = mq.size() > 0;
    chk("m_valid", 32'(o_valid), 32'(v));
    chk("m_pc",    o_pc,    v ? mq[0].pc    : 32'h0);
    chk("m_instr", o_instr, v ? mq[0].instr : 32'h0);
    chk("m_occupancy", 32'(o_occupancy), 32'(mq.size()));
    chk("m_fetch_pc", o_fetch_pc, m_fpc);
    chk("m_halted", 32'(o_halted), 32'(m_halted));
    chk("m_cycle_count", o_cycle_count, m_cnt);
  endtask

  // Inputs are set between edges; the model and DUT both see them at the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic idle();
    i_redirect = 0; i_redirect_pc = 0; i_debug_mode = 0; i_step = 0;
    i_ready = 0; i_imem_wr_en = 0; i_imem_wr_addr = 0; i_imem_wr_data = 0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    i_imem_wr_en = 1; i_imem_wr_addr = addr; i_imem_wr_data = data;
    cyc();
    i_imem_wr_en = 0;
  endtask

  task automatic do_reset();
    idle();
    i_rst = 0; #1;
    model_reset();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_occ", 32'(o_occupancy), 0);
    cyc(); cyc();
  endtask

  task automatic release_reset();
    i_rst = 1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit          ready;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    int          occ;
    logic [31:0] fpc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mkv(bit r, bit vl, logic [31:0] pc, int occ, logic [31:0] fpc);
    vec_t t;
    t.ready = r; t.valid = vl; t.pc = vl ? pc : 32'h0;
    t.instr = vl ? 32'h1000 + (pc >> 2) : 32'h0;
    t.occ = occ; t.fpc = fpc;
    return t;
  endfunction

  logic [31:0] got[$];
  bit          stale;

  initial begin
    idle();
    model_reset();
    // Fill memory while held in reset: words 0..7 = 0x1000+i, others 0x2000+i.
    for (int i = 0; i < MEM_DEPTH; i++)
      write_word(32'(i * 4), (i < 8) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
    chk("reset_fetch_pc", o_fetch_pc, RESET_PC);
    chk("reset_count", o_cycle_count, 0);

    // --- startup throughput, then backpressure and release (table) ---
    tbl.push_back(mkv(1, 0, 32'h00, 0, 32'h04));
    tbl.push_back(mkv(1, 1, 32'h00, 1, 32'h08));
    tbl.push_back(mkv(1, 1, 32'h04, 1, 32'h0C));
    tbl.push_back(mkv(0, 1, 32'h04, 2, 32'h10));
    tbl.push_back(mkv(0, 1, 32'h04, 3, 32'h14));
    tbl.push_back(mkv(0, 1, 32'h04, 4, 32'h14));
    tbl.push_back(mkv(0, 1, 32'h04, 4, 32'h14));
    tbl.push_back(mkv(1, 1, 32'h08, 3, 32'h14));
    tbl.push_back(mkv(1, 1, 32'h0C, 2, 32'h18));
    tbl.push_back(mkv(1, 1, 32'h10, 2, 32'h1C));
    tbl.push_back(mkv(1, 1, 32'h14, 2, 32'h20));
    tbl.push_back(mkv(1, 1, 32'h18, 2, 32'h24));
    tbl.push_back(mkv(1, 1, 32'h1C, 2, 32'h28));
    release_reset();
    foreach (tbl[k]) begin
      i_ready = tbl[k].ready;
      cyc();
      chk($sformatf("tbl%0d_valid", k), 32'(o_valid), 32'(tbl[k].valid));
      chk($sformatf("tbl%0d_pc", k), o_pc, tbl[k].pc);
      chk($sformatf("tbl%0d_instr", k), o_instr, tbl[k].instr);
      chk($sformatf("tbl%0d_occ", k), 32'(o_occupancy), 32'(tbl[k].occ));
      chk($sformatf("tbl%0d_fetch_pc", k), o_fetch_pc, tbl[k].fpc);
    end

    // --- saturation with ready=0 from reset, then in-order drain ---
    do_reset(); release_reset();
    for (int i = 0; i < 8; i++) cyc();
    chk("sat_occ", 32'(o_occupancy), 4);
    chk("sat_fetch_pc", o_fetch_pc, 32'h10);
    i_ready = 1;
    got.delete();
    for (int i = 0; i < 20 && got.size() < 8; i++) begin
      if (o_valid) got.push_back(o_pc);
      if (o_valid) chk("drain_instr", o_instr, 32'h1000 + (o_pc >> 2));
      cyc();
    end
    chk("drain_count", 32'(got.size()), 8);
    foreach (got[k]) chk($sformatf("drain_pc%0d", k), got[k], 32'(k * 4));

    // --- redirect with 3 queued entries and one read in flight ---
    do_reset(); release_reset();
    for (int i = 0; i < 4; i++) cyc();
    chk("redir_pre_occ", 32'(o_occupancy), 3);
    i_redirect = 1; i_redirect_pc = 32'h40;
    cyc();
    i_redirect = 0;
    chk("redir_valid", 32'(o_valid), 0);
    chk("redir_occ", 32'(o_occupancy), 0);
    chk("redir_fetch_pc", o_fetch_pc, 32'h40);
    cyc();
    chk("redir_gap_valid", 32'(o_valid), 0);
    cyc();
    chk("redir_head_pc", o_pc, 32'h40);
    chk("redir_head_instr", o_instr, 32'h2010);
    i_ready = 1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid && o_pc == 32'h0C) stale = 1;
      cyc();
    end
    chk("redir_stale_seen", 32'(stale), 0);

    // --- HALT word at pc 0x0C ---
    do_reset();
    write_word(32'h0C, HALT);
    release_reset();
    i_ready = 1;
    for (int i = 0; i < 5; i++) cyc();
    chk("halt_flag", 32'(o_halted), 1);
    chk("halt_head_pc", o_pc, 32'h0C);
    chk("halt_head_instr", o_instr, HALT);
    chk("halt_fetch_pc", o_fetch_pc, 32'h10);
    chk("halt_count", o_cycle_count, 5);
    for (int i = 0; i < 5; i++) cyc();
    chk("halt_hold_fetch_pc", o_fetch_pc, 32'h10);
    chk("halt_hold_count", o_cycle_count, 5);
    chk("halt_hold_valid", 32'(o_valid), 0);
    i_redirect = 1; i_redirect_pc = 32'h0;
    cyc();
    i_redirect = 0;
    chk("halt_clear", 32'(o_halted), 0);
    chk("halt_clear_fetch_pc", o_fetch_pc, 32'h0);
    write_word(32'h0C, 32'h1003);

    // --- debug stepping: three spaced pulses ---
    do_reset();
    i_debug_mode = 1;
    release_reset();
    for (int s = 0; s < 3; s++) begin
      i_step = 1; cyc(); i_step = 0;
      for (int i = 0; i < 4; i++) cyc();
    end
    chk("dbg_occ", 32'(o_occupancy), 3);
    chk("dbg_count", o_cycle_count, 3);
    chk("dbg_fetch_pc", o_fetch_pc, 32'h0C);
    i_ready = 1;
    got.delete();
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      if (o_valid) got.push_back(o_pc);
      cyc();
    end
    chk("dbg_entries", 32'(got.size()), 3);
    foreach (got[k]) chk($sformatf("dbg_pc%0d", k), got[k], 32'(k * 4));
    chk("dbg_count_after", o_cycle_count, 3);

    // --- asynchronous reset between edges ---
    do_reset(); release_reset();
    i_ready = 1;
    for (int i = 0; i < 6; i++) cyc();
    #2;
    i_rst = 0;
    #1;
    model_reset();
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_pc", o_pc, 0);
    chk("arst_instr", o_instr, 0);
    chk("arst_occ", 32'(o_occupancy), 0);
    chk("arst_halted", 32'(o_halted), 0);
    chk("arst_count", o_cycle_count, 0);
    chk("arst_fetch_pc", o_fetch_pc, RESET_PC);
    cyc();
    release_reset();
    cyc(); cyc();
    chk("arst_refetch_pc", o_pc, RESET_PC);
    chk("arst_refetch_instr", o_instr, 32'h1000);

    // --- randomized traffic against the model ---
    do_reset(); release_reset();
    for (int n = 0; n < 4000; n++) begin
      i_redirect = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0:       i_redirect_pc = 32'hFFFF_FFF8;
        1:       i_redirect_pc = $urandom() & ~32'h3;
        default: i_redirect_pc = 32'($urandom_range(0, 63)) << 2;
      endcase
      if ($urandom_range(0, 49) == 0) i_debug_mode = ~i_debug_mode;
      i_step  = $urandom_range(0, 1) == 1;
      i_ready = $urandom_range(0, 3) != 0;
      i_imem_wr_en   = ($urandom_range(0, 5) == 0);
      i_imem_wr_addr = $urandom();
      i_imem_wr_data = ($urandom_range(0, 2) == 0) ? HALT : $urandom();
      cyc();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
